bird_physics: RTL and testbench

//   Vertical-motion engine for the bird, directly downstream of the flap button

---
 rtl/bird_physics_if.sv | 25 ++
 rtl/bird_physics.sv | 125 ++++++++++++
 tb/tb_bird_physics.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bird_physics_if.sv
// Control and status bundle between the game front end and the bird motion engine.
// The engine takes the slave modport. Whatever drives it takes the master modport.
interface bird_physics_if #(
  parameter int Y_W = 10,
  parameter int V_W = 8
);
  logic           flap_pulse;
  logic           frame_tick;
  logic           collision;
  logic           restart;
  logic [Y_W-1:0] bird_y;
  logic [V_W-1:0] bird_vy;
  logic [1:0]     state;
  logic           dead;

  modport master (
    output flap_pulse, frame_tick, collision, restart,
    input  bird_y, bird_vy, state, dead
  );

  modport slave (
    input  flap_pulse, frame_tick, collision, restart,
    output bird_y, bird_vy, state, dead
  );
endinterface

// File: rtl/bird_physics.sv
// Bird vertical-motion engine: integrates gravity and flaps once per frame.
// It also runs the IDLE/FLYING/DEAD life cycle.
module bird_physics #(
  parameter int Y_W      = 10,
  parameter int V_W      = 8,
  parameter int Y_START  = 240,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 464,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -8,
  parameter int VMAX     = 10
) (
  input  logic           clk,
  input  logic           reset,
  bird_physics_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FLYING = 2'b01,
    DEAD   = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [Y_W-1:0]        birdY_q, birdY_d;
  logic signed [V_W-1:0] birdVy_q, birdVy_d;
  logic                  flapPend_q, flapPend_d;
  logic                  dead_q, dead_d;

  logic                  flap;
  logic signed [V_W:0]   vyGrav;
  logic signed [V_W-1:0] vyNext;
  logic signed [Y_W+1:0] ySum;

  // Candidate velocity and position for a flying tick. The sum is two bits wider so it cannot wrap.
  always_comb begin
    flap   = flapPend_q | bus.flap_pulse;
    vyGrav = $signed({birdVy_q[V_W-1], birdVy_q}) + $signed((V_W+1)'(GRAVITY));
    if (flap)
      vyNext = V_W'(FLAP_VEL);
    else if (vyGrav > $signed((V_W+1)'(VMAX)))
      vyNext = V_W'(VMAX);
    else
      vyNext = vyGrav[V_W-1:0];
    ySum = $signed({2'b00, birdY_q}) +
           $signed({{(Y_W+2-V_W){vyNext[V_W-1]}}, vyNext});
  end

  always_comb begin
    state_d    = state_q;
    birdY_d    = birdY_q;
    birdVy_d   = birdVy_q;
    flapPend_d = flapPend_q | bus.flap_pulse;

    if (bus.restart) begin
      state_d    = IDLE;
      birdY_d    = Y_W'(Y_START);
      birdVy_d   = '0;
      flapPend_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.frame_tick) begin
            flapPend_d = 1'b0;
            if (flap) begin
              state_d  = FLYING;
              birdVy_d = V_W'(FLAP_VEL);
            end
          end
        end
        FLYING: begin
          // Collision kills immediately and swallows any tick in the same cycle.
          if (bus.collision) begin
            state_d    = DEAD;
            flapPend_d = 1'b0;
          end else if (bus.frame_tick) begin
            flapPend_d = 1'b0;
            if (ySum < $signed((Y_W+2)'(Y_MIN))) begin
              birdY_d  = Y_W'(Y_MIN);
              birdVy_d = '0;
            end else if (ySum >= $signed((Y_W+2)'(Y_MAX))) begin
              birdY_d  = Y_W'(Y_MAX);
              birdVy_d = '0;
              state_d  = DEAD;
            end else begin
              birdY_d  = ySum[Y_W-1:0];
              birdVy_d = vyNext;
            end
          end
        end
        DEAD: begin
          flapPend_d = 1'b0;
        end
        default: begin
          state_d    = IDLE;
          flapPend_d = 1'b0;
        end
      endcase
    end

    dead_d = (state_d == DEAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      birdY_q    <= Y_W'(Y_START);
      birdVy_q   <= '0;
      flapPend_q <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      birdY_q    <= birdY_d;
      birdVy_q   <= birdVy_d;
      flapPend_q <= flapPend_d;
      dead_q     <= dead_d;
    end
  end

  assign bus.bird_y  = birdY_q;
  assign bus.bird_vy = birdVy_q;
  assign bus.state   = state_q;
  assign bus.dead    = dead_q;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics. Expected trajectories are worked out by hand.
module tb_bird_physics;

  logic clk;
  logic reset;
  int   checkCount;
  int   errCount;

  localparam int ST_IDLE   = 0;
  localparam int ST_FLYING = 1;
  localparam int ST_DEAD   = 2;

  bird_physics_if bus ();

  bird_physics dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkBird(input string tag, input int y, input int vy, input int st);
    checkOutput({tag, ".y"}, int'(bus.bird_y), y);
    checkOutput({tag, ".vy"}, int'($signed(bus.bird_vy)), vy);
    checkOutput({tag, ".state"}, int'(bus.state), st);
    checkOutput({tag, ".dead"}, int'(bus.dead), (st == ST_DEAD) ? 1 : 0);
  endtask

  // Drive one clock of inputs, then sample shortly after the edge.
  task automatic applyStimulus(input logic flap, input logic tick, input logic coll, input logic rst);
    @(negedge clk);
    bus.flap_pulse = flap;
    bus.frame_tick = tick;
    bus.collision  = coll;
    bus.restart    = rst;
    @(posedge clk);
    #1;
    bus.flap_pulse = 1'b0;
    bus.frame_tick = 1'b0;
    bus.collision  = 1'b0;
    bus.restart    = 1'b0;
  endtask

  initial begin
    checkCount     = 0;
    errCount       = 0;
    bus.flap_pulse = 1'b0;
    bus.frame_tick = 1'b0;
    bus.collision  = 1'b0;
    bus.restart    = 1'b0;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkBird("reset", 240, 0, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;

    // A tick without a flap does not launch the bird from IDLE.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBird("idleTick", 240, 0, ST_IDLE);

    // A lone pulse arms the flap, and the next tick launches.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBird("launch", 240, -8, ST_FLYING);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBird("tick2", 233, -7, ST_FLYING);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBird("tick3", 227, -6, ST_FLYING);

    // Coast up to (257,9). Then arm a flap and hit reset asynchronously.
    for (int i = 1; i <= 15; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBird("coast", 257, 9, ST_FLYING);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkBird("asyncReset", 240, 0, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBird("pendDropped", 240, 0, ST_IDLE);

    // Free fall from launch to the floor. Velocity saturates at 10.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkBird("fallLaunch", 240, -8, ST_FLYING);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 36; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 13) checkBird("fall13", 240, 7, ST_FLYING);
      if (i == 16) checkBird("fall16", 267, 10, ST_FLYING);
      if (i == 17) checkBird("vmaxHold", 277, 10, ST_FLYING);
      if (i == 35) checkBird("fall35", 457, 10, ST_FLYING);
      if (i == 36) checkBird("floor", 464, 0, ST_DEAD);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBird("deadFrozen", 464, 0, ST_DEAD);

    // Several pulses in one frame count as one flap. The pending flag clears on tick.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkBird("restart1", 240, 0, ST_IDLE);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkBird("multiIdle", 240, -8, ST_FLYING);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBird("multiIdleNext", 233, -7, ST_FLYING);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkBird("multiFly", 225, -8, ST_FLYING);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBird("multiFlyNext", 218, -7, ST_FLYING);

    // Flap on every tick: the bird reaches the ceiling and clamps there.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 31; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 30) checkBird("ceil30", 0, -8, ST_FLYING);
      if (i == 31) checkBird("ceil31", 0, 0, ST_FLYING);
    end

    // A collision that coincides with a tick freezes the bird at y=200.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkBird("at200", 200, -8, ST_FLYING);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkBird("collTick", 200, -8, ST_DEAD);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkBird("restart2", 240, 0, ST_IDLE);

    // IDLE ignores collisions. A collision without a tick still kills in FLYING.
    // Restart takes priority over collision.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkBird("idleColl", 240, -8, ST_FLYING);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkBird("collOnly", 240, -8, ST_DEAD);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkBird("restartPrio", 240, 0, ST_IDLE);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
